// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and issue.
// slave is the decode queue's view; master is the fetch/issue side.
interface decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             redirect;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [2:0]       out_ex_unit;
  logic [3:0]       out_op;
  logic [2:0]       out_funct3;
  logic [REG_W-1:0] out_rs1;
  logic [REG_W-1:0] out_rs2;
  logic             out_rs1_en;
  logic             out_rs2_en;
  logic [REG_W-1:0] out_rd;
  logic             out_rd_en;
  logic [XLEN-1:0]  out_imm;
  logic             out_imm_en;
  logic             out_pc_en;
  logic             out_link;
  logic             out_load;
  logic             out_store;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, redirect, out_ready,
    output in_ready, out_valid, out_pc, out_ex_unit, out_op, out_funct3,
           out_rs1, out_rs2, out_rs1_en, out_rs2_en, out_rd, out_rd_en,
           out_imm, out_imm_en, out_pc_en, out_link, out_load, out_store,
           out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, redirect, out_ready,
    input  in_ready, out_valid, out_pc, out_ex_unit, out_op, out_funct3,
           out_rs1, out_rs2, out_rs1_en, out_rs2_en, out_rd, out_rd_en,
           out_imm, out_imm_en, out_pc_en, out_link, out_load, out_store,
           out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage: circular instruction queue feeding a registered decode slot,
// with flush/redirect and a fetch block that holds after every jump until redirect.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] EX_ERR = 3'd0, EX_ALU = 3'd1, EX_FWD = 3'd2,
                         EX_MEM = 3'd3, EX_BRU = 3'd4;
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2,
                         OP_SLL = 4'd3, OP_SLT = 4'd4, OP_SLTU = 4'd5,
                         OP_XOR = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8,
                         OP_OR = 4'd9, OP_AND = 4'd10;

  typedef struct packed {
    logic [2:0]       ex_unit;
    logic [3:0]       op;
    logic [2:0]       funct3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_en;
    logic             rs2_en;
    logic [REG_W-1:0] rd;
    logic             rd_en;
    logic [XLEN-1:0]  imm;
    logic             imm_en;
    logic             pc_en;
    logic             link;
    logic             load;
    logic             store;
    logic             illegal;
  } dec_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t            d;
    logic            bad;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    d     = '0;
    bad   = 1'b0;
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm_i = XLEN'($signed(inst[31:20]));
    imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    shamt = XLEN'(inst[24:20]);
    case (inst[6:0])
      7'b0110011: begin
        d.ex_unit = EX_ALU;
        d.op = base_op(f3);
        {d.rs1_en, d.rs2_en, d.rd_en} = 3'b111;
        // funct7=0100000 is only meaningful for SUB and SRA
        if (f7 == 7'h20 && f3 == 3'b000)      d.op = OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) d.op = OP_SRA;
        else if (f7 != 7'h00)                 bad = 1'b1;
      end
      7'b0010011: begin
        d.ex_unit = EX_ALU;
        d.op = base_op(f3);
        {d.rs1_en, d.rd_en, d.imm_en} = 3'b111;
        d.imm = imm_i;
        if (f3 == 3'b001) begin
          d.imm = shamt;
          bad = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          d.imm = shamt;
          if (f7 == 7'h20)      d.op = OP_SRA;
          else if (f7 != 7'h00) bad = 1'b1;
        end
      end
      7'b0110111: begin
        d.ex_unit = EX_FWD;
        {d.rd_en, d.imm_en} = 2'b11;
        d.imm = imm_u;
      end
      7'b0010111: begin
        d.ex_unit = EX_ALU;
        d.op = OP_ADD;
        {d.rd_en, d.imm_en, d.pc_en} = 3'b111;
        d.imm = imm_u;
      end
      7'b1101111: begin
        d.ex_unit = EX_ALU;
        d.op = OP_ADD;
        {d.rd_en, d.imm_en, d.pc_en, d.link} = 4'b1111;
        d.imm = imm_j;
      end
      7'b1100111: begin
        d.ex_unit = EX_ALU;
        d.op = OP_ADD;
        {d.rs1_en, d.rd_en, d.link} = 3'b111;
        d.imm = imm_i;
        bad = (f3 != 3'b000);
      end
      7'b1100011: begin
        d.ex_unit = EX_BRU;
        d.funct3 = f3;
        {d.rs1_en, d.rs2_en, d.pc_en} = 3'b111;
        d.imm = imm_b;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        d.ex_unit = EX_MEM;
        d.funct3 = f3;
        {d.rs1_en, d.rd_en, d.load} = 3'b111;
        d.imm = imm_i;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        d.ex_unit = EX_MEM;
        d.funct3 = f3;
        {d.rs1_en, d.rs2_en, d.store} = 3'b111;
        d.imm = imm_s;
        bad = (f3 > 3'b010);
      end
      default: bad = 1'b1;
    endcase
    if (d.rs1_en) d.rs1 = REG_W'(inst[19:15]);
    if (d.rs2_en) d.rs2 = REG_W'(inst[24:20]);
    if (d.rd_en)  d.rd  = REG_W'(inst[11:7]);
    if (d.rd == '0) d.rd_en = 1'b0;
    if (bad) begin
      d = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [31:0]     q_inst_p0 [DEPTH];
  logic [XLEN-1:0] q_pc_p0   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            jump_block, rst_done;
  dec_t            slot_p1;
  logic [XLEN-1:0] pc_p1;
  logic            vld_p1;
  dec_t            head_dec;
  logic            empty, full, kill, push, pop;

  always_comb begin
    head_dec     = decode(q_inst_p0[rd_ptr]);
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    kill         = bus.flush || bus.redirect;
    bus.in_ready = rst_done && !full && !jump_block;
    push         = bus.in_valid && bus.in_ready;
    pop          = !empty && (!vld_p1 || bus.out_ready);
  end

  // stage p0: queue storage
  always_ff @(posedge clk) begin
    if (push && !kill) begin
      q_inst_p0[wr_ptr] <= bus.in_inst;
      q_pc_p0[wr_ptr]   <= bus.in_pc;
    end
  end

  // stage p1: pointers, jump block and the registered decode slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      jump_block <= 1'b0;
      vld_p1     <= 1'b0;
      slot_p1    <= '0;
      pc_p1      <= '0;
    end else begin
      rst_done <= 1'b1;
      if (kill) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        jump_block <= 1'b0;
        vld_p1     <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (pop) begin
          vld_p1  <= 1'b1;
          slot_p1 <= head_dec;
          pc_p1   <= q_pc_p0[rd_ptr];
          if (head_dec.link) jump_block <= 1'b1;
        end else if (bus.out_ready) begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid   = vld_p1;
    bus.out_pc      = pc_p1;
    bus.out_ex_unit = slot_p1.ex_unit;
    bus.out_op      = slot_p1.op;
    bus.out_funct3  = slot_p1.funct3;
    bus.out_rs1     = slot_p1.rs1;
    bus.out_rs2     = slot_p1.rs2;
    bus.out_rs1_en  = slot_p1.rs1_en;
    bus.out_rs2_en  = slot_p1.rs2_en;
    bus.out_rd      = slot_p1.rd;
    bus.out_rd_en   = slot_p1.rd_en;
    bus.out_imm     = slot_p1.imm;
    bus.out_imm_en  = slot_p1.imm_en;
    bus.out_pc_en   = slot_p1.pc_en;
    bus.out_link    = slot_p1.link;
    bus.out_load    = slot_p1.load;
    bus.out_store   = slot_p1.store;
    bus.out_illegal = slot_p1.illegal;
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, jump block, capacity, flush and async reset.
`define CHK(tag, got, exp) check(tag, 64'(got), 64'(exp))
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   accepted;
  logic [31:0] word;

  decode_queue_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    @(negedge clk);
    `CHK("rst_out_valid", bus.out_valid, 1'b0);
    `CHK("rst_ex_unit", bus.out_ex_unit, 3'd0);
    `CHK("rst_imm", bus.out_imm, 32'h0);
    `CHK("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    `CHK("in_ready_before_edge", bus.in_ready, 1'b0);
    @(negedge clk);
    `CHK("in_ready_after_edge", bus.in_ready, 1'b1);

    // ADDI x1,x2,-5
    send(32'hFFB10093, 32'h100);
    `CHK("addi_latency", bus.out_valid, 1'b0);
    @(negedge clk);
    `CHK("addi_valid", bus.out_valid, 1'b1);
    `CHK("addi_ex", bus.out_ex_unit, 3'd1);
    `CHK("addi_op", bus.out_op, 4'd1);
    `CHK("addi_rs1", bus.out_rs1, 5'd2);
    `CHK("addi_rs1_en", bus.out_rs1_en, 1'b1);
    `CHK("addi_rs2_en", bus.out_rs2_en, 1'b0);
    `CHK("addi_rd", bus.out_rd, 5'd1);
    `CHK("addi_rd_en", bus.out_rd_en, 1'b1);
    `CHK("addi_imm", bus.out_imm, 32'hFFFFFFFB);
    `CHK("addi_imm_en", bus.out_imm_en, 1'b1);
    `CHK("addi_pc", bus.out_pc, 32'h100);

    // SRAI x3,x4,7 and SRLI x3,x4,7
    send(32'h40725193, 32'h104);
    @(negedge clk);
    `CHK("srai_op", bus.out_op, 4'd8);
    `CHK("srai_imm", bus.out_imm, 32'd7);
    `CHK("srai_rd", bus.out_rd, 5'd3);
    `CHK("srai_rs1", bus.out_rs1, 5'd4);
    send(32'h00725193, 32'h108);
    @(negedge clk);
    `CHK("srli_op", bus.out_op, 4'd7);
    `CHK("srli_imm", bus.out_imm, 32'd7);

    // SUB x5,x1,x3
    send(32'h403082B3, 32'h10C);
    @(negedge clk);
    `CHK("sub_op", bus.out_op, 4'd2);
    `CHK("sub_rs2", bus.out_rs2, 5'd3);
    `CHK("sub_rs2_en", bus.out_rs2_en, 1'b1);
    `CHK("sub_rd", bus.out_rd, 5'd5);
    `CHK("sub_imm_en", bus.out_imm_en, 1'b0);

    // ADDI x0,x0,0 : rd_en suppressed for x0
    send(32'h00000013, 32'h110);
    @(negedge clk);
    `CHK("nop_ex", bus.out_ex_unit, 3'd1);
    `CHK("nop_rd_en", bus.out_rd_en, 1'b0);
    `CHK("nop_illegal", bus.out_illegal, 1'b0);

    // SW x2,8(x1)
    send(32'h0020A423, 32'h114);
    @(negedge clk);
    `CHK("sw_ex", bus.out_ex_unit, 3'd3);
    `CHK("sw_store", bus.out_store, 1'b1);
    `CHK("sw_load", bus.out_load, 1'b0);
    `CHK("sw_rd_en", bus.out_rd_en, 1'b0);
    `CHK("sw_rs1", bus.out_rs1, 5'd1);
    `CHK("sw_rs2", bus.out_rs2, 5'd2);
    `CHK("sw_imm", bus.out_imm, 32'd8);
    `CHK("sw_funct3", bus.out_funct3, 3'd2);

    // JAL x1,+8 followed by ADDI; fetch blocked until redirect
    bus.in_valid = 1'b1; bus.in_inst = 32'h008000EF; bus.in_pc = 32'h200;
    @(negedge clk);
    bus.in_inst = 32'hFFB10093; bus.in_pc = 32'h204;
    @(negedge clk);
    bus.in_valid = 1'b0;
    `CHK("jal_valid", bus.out_valid, 1'b1);
    `CHK("jal_pc", bus.out_pc, 32'h200);
    `CHK("jal_op", bus.out_op, 4'd1);
    `CHK("jal_imm", bus.out_imm, 32'd8);
    `CHK("jal_pc_en", bus.out_pc_en, 1'b1);
    `CHK("jal_link", bus.out_link, 1'b1);
    `CHK("jal_rd", bus.out_rd, 5'd1);
    `CHK("jal_block", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1; bus.in_inst = 32'h00725193; bus.in_pc = 32'h208;
    @(negedge clk);
    `CHK("drain_valid", bus.out_valid, 1'b1);
    `CHK("drain_pc", bus.out_pc, 32'h204);
    `CHK("drain_link", bus.out_link, 1'b0);
    `CHK("drain_block", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    `CHK("blocked_empty", bus.out_valid, 1'b0);
    `CHK("blocked_ready", bus.in_ready, 1'b0);
    bus.redirect = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    `CHK("redirect_ready", bus.in_ready, 1'b1);
    `CHK("redirect_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    `CHK("blocked_word_dropped", bus.out_valid, 1'b0);

    // capacity: DEPTH queue entries plus the slot
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.in_ready) accepted++;
      word = {12'(i), 5'd2, 3'b000, 5'd1, 7'h13};
      bus.in_valid = 1'b1; bus.in_inst = word; bus.in_pc = 32'h300 + 32'(4 * i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    `CHK("cap_accepted", accepted, 5);
    `CHK("cap_full_ready", bus.in_ready, 1'b0);
    `CHK("cap_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL cap_order_valid[%0d]: got %0h", k, bus.out_valid);
      end
      n_checks++;
      if (bus.out_pc !== 32'h300 + 32'(4 * k)) begin
        n_errors++;
        $display("FAIL cap_order_pc[%0d]: got %0h", k, bus.out_pc);
      end
      n_checks++;
      if (bus.out_imm !== 32'(k)) begin
        n_errors++;
        $display("FAIL cap_order_imm[%0d]: got %0h", k, bus.out_imm);
      end
      @(negedge clk);
    end
    `CHK("cap_drained", bus.out_valid, 1'b0);
    `CHK("cap_ready_again", bus.in_ready, 1'b1);

    // flush with a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_inst = 32'hFFB10093; bus.in_pc = 32'h400 + 32'(4 * i);
      @(negedge clk);
    end
    `CHK("pre_flush_valid", bus.out_valid, 1'b1);
    bus.in_inst = 32'h00725193; bus.in_pc = 32'h999; bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    `CHK("flush_valid", bus.out_valid, 1'b0);
    `CHK("flush_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_nothing_out[%0d]: got %0h", i, bus.out_valid);
      end
    end

    // asynchronous reset between edges
    bus.out_ready = 1'b0;
    send(32'hFFB10093, 32'h500);
    @(negedge clk);
    `CHK("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    `CHK("async_rst_valid", bus.out_valid, 1'b0);
    `CHK("async_rst_ex", bus.out_ex_unit, 3'd0);
    `CHK("async_rst_rd_en", bus.out_rd_en, 1'b0);
    `CHK("async_rst_pc", bus.out_pc, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    `CHK("post_rst_ready", bus.in_ready, 1'b1);

    // illegal instruction word
    bus.out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h600);
    @(negedge clk);
    `CHK("ill_valid", bus.out_valid, 1'b1);
    `CHK("ill_flag", bus.out_illegal, 1'b1);
    `CHK("ill_ex", bus.out_ex_unit, 3'd0);
    `CHK("ill_op", bus.out_op, 4'd0);
    `CHK("ill_enables", {bus.out_rs1_en, bus.out_rs2_en, bus.out_rd_en, bus.out_imm_en,
                         bus.out_pc_en, bus.out_link, bus.out_load, bus.out_store}, 8'h00);
    `CHK("ill_imm", bus.out_imm, 32'h0);
    @(negedge clk);
    `CHK("ill_no_block", bus.in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered RV32I decode stage between fetch and issue.
- Holds up to DEPTH fetched instructions in a circular queue and decodes the queue head into a registered output slot.
- Uses valid/ready handshakes on both sides, supports flush, and blocks further fetch after any jump until the fetch unit signals a redirect.
- Covers R, I (ALU), LUI, AUIPC, JAL, JALR, BRANCH, LOAD and STORE.

Parameters:
XLEN, 32, data/immediate/PC width
DEPTH, 4, instruction queue entries (power of two, >=2)
REG_W, 5, register index width

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
flush  in  1  discard queue, output slot and jump block
redirect  in  1  fetch has taken jump target; clears jump block and flushes
out_valid  out  1  output slot holds decoded instruction
out_ready  in  1  issue consumes output slot
out_pc  out  XLEN  PC of decoded instruction
out_ex_unit  out  3  0 ERR, 1 ALU, 2 FWD, 3 MEM, 4 BRU
out_op  out  4  0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND
out_funct3  out  3  inst[14:12], passed through for BRU/MEM
out_rs1 / out_rs2  out  REG_W  source indices
out_rs1_en / out_rs2_en  out  1  source read enables
out_rd  out  REG_W  destination index
out_rd_en  out  1  destination write enable
out_imm  out  XLEN  sign-extended immediate
out_imm_en  out  1  operand B is the immediate
out_pc_en  out  1  operand A is the PC
out_link  out  1  write PC+4 to rd
out_load / out_store  out  1  memory access kind
out_illegal  out  1  opcode/funct not recognised

Behaviour:
- Reset (async, any time): queue empty, pointers 0, jump block 0, out_valid 0. All out_* decode fields are 0 and out_ex_unit=ERR. in_ready goes high on the first edge after rst deasserts.
- in_ready = !full && !jump_block; it is registered-state-derived, with no look-through on same-cycle pop. A push occurs when in_valid && in_ready.
- Slot load: when queue non-empty and (!out_valid || out_ready), the head is decoded, written into the output slot and popped at the same edge. If out_ready && out_valid and the queue is empty, out_valid drops.
- Latency: accept at edge E0 -> out_valid high after E1 (1 cycle minimum). Throughput is 1/cycle sustained.
- Capacity: DEPTH queue entries plus 1 output slot.
- Pointers wrap modulo DEPTH. The count register is clog2(DEPTH)+1 bits wide, so full and empty are distinct.
- Simultaneous push and pop updates the count by 0.
- flush or redirect has priority over push/pop in the same cycle. Next state: queue empty, out_valid 0, jump_block 0. A pushed instruction in that cycle is discarded.
- jump_block is set at the edge that loads JAL or JALR into the slot. While set, in_ready=0. Instructions already queued still drain.
- Decode rules:
  - R: ALU, rs1/rs2/rd enabled, op from {funct7,funct3}.
  - I-ALU: ALU, imm=sext(inst[31:20]), imm_en. SLLI/SRLI/SRAI use imm=inst[24:20] zero-extended; inst[30]=1 selects SRA, 0 selects SRL.
  - LUI: FWD, imm={inst[31:12],12'b0}, imm_en.
  - AUIPC: ALU ADD, same imm, imm_en, pc_en.
  - JAL: ALU ADD, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}), imm_en, pc_en, link.
  - JALR: ALU ADD, rs1, I-imm, link.
  - BRANCH: BRU, rs1/rs2, B-imm, pc_en, rd_en=0.
  - LOAD: MEM, rs1, I-imm, load.
  - STORE: MEM, rs1/rs2, S-imm, store, rd_en=0.
- rd_en is forced 0 when rd==0.
- Unknown opcode or illegal funct: out_illegal=1, ex_unit ERR, op NOP, all enables 0, imm 0. It still occupies a slot and does not set jump_block.

Test Plan:
- Push 0xFFB10093 (ADDI x1,x2,-5) at pc 0x100 -> after 1 cycle out_valid=1, ALU/ADD, rs1=2 en, rd=1 en, imm=0xFFFFFFFB, imm_en=1, out_pc=0x100.
- Push 0x40725193 (SRAI x3,x4,7) -> op=SRA(8), imm=7. Push 0x00725193 (SRLI) -> op=SRL(7).
- Push 0x008000EF (JAL x1,+8) then ADDI -> imm=8, pc_en=1, link=1, in_ready=0 the cycle after load. ADDI still drains. redirect pulse -> in_ready=1, queue empty, out_valid=0.
- DEPTH=4, out_ready=0, offer 6 instructions -> exactly 5 accepted, in_ready=0. Then out_ready=1 -> 5 outputs in order, one per cycle, pointers wrap.
- Fill 3 entries, assert flush together with in_valid -> next cycle out_valid=0, count 0, the pushed word is never output.
- Assert rst mid-stream between edges -> outputs clear immediately without a clock edge. Push 0xFFFFFFFF -> out_illegal=1, ex_unit=0, all enables 0.
